param_reduce_gate: RTL and testbench
====================================

Name: param_reduce_gate

Overview:
- Parametrised successor to the team's fixed 4-input OR gate.
- Reduces an N-bit input vector with a runtime-selected logic function (OR/AND/XOR/NOR/NAND/XNOR) and also reports the population count.
- Results pass through a registered valid/ready pipeline with a 2-entry skid buffer, so the block can sit between handshaked producers and consumers in lab datapaths.

Parameters:
- N, 4, number of input bits reduced (legal range 2..32).
- CNT_W, $clog2(N+1), width of the population-count output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N  vector to reduce.
- in_mode  input  3  reduction function, sampled together with in_data.
- in_valid  input  1  producer has a transaction.
- in_ready  output  1  block can accept a transaction.
- out_bit  output  1  reduction result.
- out_count  output  CNT_W  number of 1s in the accepted in_data.
- out_err  output  1  in_mode was reserved (6 or 7).
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- sticky_clr  input  1  synchronous clear of sticky_q.
- sticky_q  output  1  OR-accumulation of out_bit over accepted transactions.

Behaviour:
- Reset is asserted by rst_n low, takes effect immediately and asynchronously. Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - Buffer count = 0.
  - out_valid = 0, out_bit = 0, out_count = 0, out_err = 0.
  - sticky_q = 0.
  - in_ready = 1. It is combinational from the count, so it reads 1 during and after reset.
- Accept: the input transfers on a rising edge where in_valid && in_ready. Push: the output transfers on a rising edge where out_valid && out_ready.
- Mode encoding:
  - 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR.
  - 6, 7 reserved: out_bit = 0 and out_err = 1 for that entry.
- out_count = popcount(in_data). It is independent of mode and always computed, including for reserved modes.
- Latency: a transaction accepted at edge k is visible on the outputs (out_valid = 1) after edge k. One cycle, with no combinational path from in_* to out_*.
- Buffer: 2-entry FIFO, strict order. in_ready = (count < 2). out_valid = (count > 0). Output fields come from the head entry.
- Count transitions per edge:
  - Push only: count + 1.
  - Pop only: count − 1.
  - Push and pop at count 1: count stays 1; the new data becomes the head.
  - At count 2 no push is possible; a pop frees one slot and in_ready rises the next cycle.
  - At count 0 no pop is possible.
- out_* hold their value while out_valid && !out_ready (no change until popped).
- While out_valid = 0, outputs hold the last popped values. Verification must not check them in that state.
- Sticky:
  - On accept: sticky_q <= sticky_q | result_bit.
  - sticky_clr takes effect on the same edge.
  - If clear and accept coincide, sticky_q <= result_bit (clear first, then set).
  - out_err entries contribute 0.
- Reset mid-operation: buffered entries are discarded immediately and out_valid drops asynchronously. There is no partial state.

Optional Feature:
- Macro: PARAM_REDUCE_STICKY_EN.
- Defined: sticky logic as above.
- Undefined: sticky_q is tied to 0, sticky_clr is ignored, and no sticky flop is inferred. The ports remain, so the interface is identical.

Decomposition:
- Package reduce_pkg holds:
  - Mode localparams MODE_OR..MODE_XNOR.
  - MODE_W = 3.
  - The result-entry struct/field widths: bit, count, err.
  - A function reduce_fn(data, mode) returning {err, bit}.
- Sub-module: reduce_skid_buf, a generic 2-entry valid/ready FIFO parametrised by entry width.
- The top module contains only the combinational reduction, the popcount, and the sticky register.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 → out_valid = 0, in_ready = 1, sticky_q = 0. Release reset, send in_data = 4'b0000, mode 0 → next cycle out_bit = 0, out_count = 0.
- Mode sweep: in_data = 4'b1011 in modes 0..5 → out_bit = 1, 0, 1, 0, 1, 0; out_count = 3 each. Mode 6 → out_bit = 0, out_err = 1, out_count = 3.
- Backpressure: out_ready = 0, push 3 back-to-back (1111 AND, 0001 AND, 0110 XOR) → in_ready drops after the 2nd accept and the 3rd waits. Raise out_ready → outputs 1, 0, 0 in order with no loss or duplication.
- Simultaneous push/pop at count 1 with out_ready = 1 and continuous in_valid → count stays 1, throughput one result per cycle.
- Sticky (macro defined): accept 0000 OR (sticky_q 0), then 0100 OR (sticky_q 1). Assert sticky_clr together with an accept of 0000 OR → sticky_q 0. With the macro undefined, the same stimulus → sticky_q always 0.
- Async reset mid-stream: with 2 entries buffered, pulse rst_n low between clock edges → out_valid falls immediately and no stale entry appears after release.

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared definitions for param_reduce_gate: mode encodings, result-entry layout
// and the reduction function.
package reduce_pkg;

  localparam int MODE_W = 3;
  localparam int MAX_N  = 32;

  localparam logic [MODE_W-1:0] MODE_OR   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_AND  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

  // Result entry is packed as {err, count, bit}; count width depends on N.
  localparam int RES_BIT_W = 1;
  localparam int RES_ERR_W = 1;

  function automatic int entry_w(input int cnt_w);
    return RES_ERR_W + cnt_w + RES_BIT_W;
  endfunction

  // Reduces the low n bits of data; returns {err, bit}. Bits at or above n are masked out.
  function automatic logic [1:0] reduce_fn(input logic [MAX_N-1:0] data,
                                           input logic [MODE_W-1:0] mode,
                                           input int n);
    logic or_v;
    logic and_v;
    logic xor_v;
    logic en_v;
    logic [1:0] res_v;
    or_v  = 1'b0;
    and_v = 1'b1;
    xor_v = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      en_v  = (i < n);
      or_v  = or_v  | (data[i] & en_v);
      and_v = and_v & (data[i] | ~en_v);
      xor_v = xor_v ^ (data[i] & en_v);
    end
    case (mode)
      MODE_OR:   res_v = {1'b0, or_v};
      MODE_AND:  res_v = {1'b0, and_v};
      MODE_XOR:  res_v = {1'b0, xor_v};
      MODE_NOR:  res_v = {1'b0, ~or_v};
      MODE_NAND: res_v = {1'b0, ~and_v};
      MODE_XNOR: res_v = {1'b0, ~xor_v};
      default:   res_v = {1'b1, 1'b0};
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/reduce_skid_buf.sv
// Generic 2-entry valid/ready FIFO with registered head; strict ordering.
module reduce_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push_s;
  logic         pop_s;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q > 2'd0);
  assign out_data  = head_q;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Next-state: push and pop together only happen at count 1, so the new entry becomes head.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push_s, pop_s})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
      end
      2'b11: begin
        head_d = in_data;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/param_reduce_gate.sv
// N-bit runtime-selectable reduction plus popcount behind a 2-entry skid buffer.
// Optional sticky OR-accumulator enabled by PARAM_REDUCE_STICKY_EN.
module param_reduce_gate
  import reduce_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              sticky_clr,
  output logic              sticky_q
);

  localparam int ENTRY_W = entry_w(CNT_W);

  logic [1:0]         red_s;
  logic [CNT_W-1:0]   popcnt_s;
  logic [ENTRY_W-1:0] in_entry_s;
  logic [ENTRY_W-1:0] out_entry_s;

  // Reduction result {err, bit} for the current input.
  always_comb begin
    red_s = reduce_fn(MAX_N'(in_data), in_mode, N);
  end

  // Population count, independent of mode.
  always_comb begin
    popcnt_s = '0;
    for (int i = 0; i < N; i++) begin
      popcnt_s = popcnt_s + CNT_W'(in_data[i]);
    end
  end

  assign in_entry_s = {red_s[1], popcnt_s, red_s[0]};

  reduce_skid_buf #(
    .W (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_entry_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_entry_s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_err   = out_entry_s[ENTRY_W-1];
  assign out_count = out_entry_s[CNT_W:1];
  assign out_bit   = out_entry_s[0];

`ifdef PARAM_REDUCE_STICKY_EN
  logic accept_s;
  logic sticky_d;

  assign accept_s = in_valid & in_ready;

  // Clear applies before the set so a coinciding accept still records its bit.
  always_comb begin
    if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
    if (accept_s) begin
      sticky_d = sticky_d | red_s[0];
    end else begin
      sticky_d = sticky_d;
    end
  end

  // Sticky accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`else
  logic unused_sticky_clr_s;

  assign unused_sticky_clr_s = sticky_clr;
  assign sticky_q            = 1'b0;
`endif

endmodule

// File: tb/tb_param_reduce_gate.sv
// Directed self-checking bench for param_reduce_gate (N = 4).
module tb_param_reduce_gate;

`ifdef PARAM_REDUCE_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic [2:0] in_mode;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic [2:0] out_count;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       sticky_clr;
  logic       sticky_q;

  int tests;
  int fails;

  param_reduce_gate #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bit    (out_bit),
    .out_count  (out_count),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sticky_clr (sticky_clr),
    .sticky_q   (sticky_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'b1111; in_mode = 3'd0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (sticky_q !== 1'b0) begin fails++; $display("FAIL reset_sticky got %b exp 0", sticky_q); end
    tests++; if ({out_bit, out_count, out_err} !== 5'b0) begin fails++; $display("FAIL reset_fields got %b exp 00000", {out_bit, out_count, out_err}); end
    in_data = 4'b0000; in_mode = 3'd0;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0 || out_count !== 3'd0)
      begin fails++; $display("FAIL first_txn got v=%b b=%b c=%0d exp v=1 b=0 c=0", out_valid, out_bit, out_count); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL first_pop got %b exp 0", out_valid); end
  endtask

  task automatic test_mode_sweep();
    logic [7:0] exp_bit;
    logic [7:0] exp_err;
    exp_bit = 8'b0001_0101;  // index = mode: 1,0,1,0,1,0,0,0
    exp_err = 8'b1100_0000;
    out_ready = 1'b1;
    in_data = 4'b1011;
    for (int m = 0; m < 8; m++) begin
      in_mode = 3'(m); in_valid = 1'b1;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_bit !== exp_bit[m] || out_err !== exp_err[m] || out_count !== 3'd3 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL mode_%0d got v=%b b=%b e=%b c=%0d r=%b exp v=1 b=%b e=%b c=3 r=1",
                 m, out_valid, out_bit, out_err, out_count, in_ready, exp_bit[m], exp_err[m]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sweep_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d [4];
    logic [3:0] eb;
    d[0] = 4'b0001; d[1] = 4'b0011; d[2] = 4'b0111; d[3] = 4'b1111;
    eb = 4'b0101;
    out_ready = 1'b1; in_mode = 3'd2;
    for (int i = 0; i < 4; i++) begin
      in_data = d[i]; in_valid = 1'b1;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_bit !== eb[i] || out_count !== 3'(i + 1) || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_%0d got v=%b b=%b c=%0d r=%b exp v=1 b=%b c=%0d r=1",
                 i, out_valid, out_bit, out_count, in_ready, eb[i], i + 1);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_data = 4'b1111; in_mode = 3'd1; in_valid = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    in_data = 4'b0001; in_mode = 3'd1;
    tick();
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bit !== 1'b1 || out_count !== 3'd4)
      begin fails++; $display("FAIL bp_full got r=%b v=%b b=%b c=%0d exp r=0 v=1 b=1 c=4", in_ready, out_valid, out_bit, out_count); end
    in_data = 4'b0110; in_mode = 3'd2;
    tick(); tick();
    tests++; if (in_ready !== 1'b0 || out_bit !== 1'b1 || out_count !== 3'd4)
      begin fails++; $display("FAIL bp_hold got r=%b b=%b c=%0d exp r=0 b=1 c=4", in_ready, out_bit, out_count); end
    out_ready = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_bit !== 1'b0 || out_count !== 3'd1)
      begin fails++; $display("FAIL bp_second got r=%b v=%b b=%b c=%0d exp r=1 v=1 b=0 c=1", in_ready, out_valid, out_bit, out_count); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0 || out_count !== 3'd2 || out_err !== 1'b0)
      begin fails++; $display("FAIL bp_third got v=%b b=%b c=%0d e=%b exp v=1 b=0 c=2 e=0", out_valid, out_bit, out_count, out_err); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0 (duplicate)", out_valid); end
  endtask

  task automatic test_sticky();
    out_ready = 1'b1; in_mode = 3'd0; in_valid = 1'b1;
    in_data = 4'b0000;
    tick();
    tests++; if (sticky_q !== 1'b0) begin fails++; $display("FAIL sticky_zero got %b exp 0", sticky_q); end
    in_data = 4'b0100;
    tick();
    tests++; if (sticky_q !== STICKY_EN) begin fails++; $display("FAIL sticky_set got %b exp %b", sticky_q, STICKY_EN); end
    in_data = 4'b0000; sticky_clr = 1'b1;
    tick();
    tests++; if (sticky_q !== 1'b0) begin fails++; $display("FAIL sticky_clr got %b exp 0", sticky_q); end
    in_data = 4'b0100;
    tick();
    tests++; if (sticky_q !== STICKY_EN) begin fails++; $display("FAIL sticky_clr_set got %b exp %b", sticky_q, STICKY_EN); end
    in_data = 4'b0000; in_mode = 3'd6; sticky_clr = 1'b0;
    tick();
    tests++; if (sticky_q !== STICKY_EN) begin fails++; $display("FAIL sticky_err_hold got %b exp %b", sticky_q, STICKY_EN); end
    in_valid = 1'b0; sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests++; if (sticky_q !== 1'b0) begin fails++; $display("FAIL sticky_clr_only got %b exp 0", sticky_q); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_mode = 3'd0; in_valid = 1'b1;
    in_data = 4'b0011;
    tick();
    in_data = 4'b0101;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL ar_full got v=%b r=%b exp v=1 r=0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL ar_drop got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_stale got %b exp 0", out_valid); end
    in_data = 4'b1000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1 || out_count !== 3'd1)
      begin fails++; $display("FAIL ar_fresh got v=%b b=%b c=%0d exp v=1 b=1 c=1", out_valid, out_bit, out_count); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mode_sweep();
    test_back_to_back();
    test_backpressure();
    test_sticky();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
